// File: rtl/timer_device.sv
// timer_device: memory-mapped free-running cycle counter with a sticky,
// software-acknowledged interrupt request toward cp0.
//   0xffff001c  load: cycle count      store: interrupt cycle
//   0xffff006c  store: acknowledge     load: 0
//   0xffff0020  load/store: reload period (only with TIMER_PERIODIC_EN)
// Optional feature macro: TIMER_PERIODIC_EN (periodic reload of the compare
// value on each match while the period is non-zero).
module timer_device (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic        TimerInterrupt,
  output logic        TimerAddress,
  output logic [31:0] cycle
);

  localparam logic [31:0] CYCLE_ADDR  = 32'hffff_001c;
  localparam logic [31:0] ACK_ADDR    = 32'hffff_006c;
  localparam logic [31:0] PERIOD_ADDR = 32'hffff_0020;

  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] interrupt_cycle_q, interrupt_cycle_d;
  logic        irq_q, irq_d;
  logic        hit_cycle, hit_ack, hit_period;
  logic        match;
`ifdef TIMER_PERIODIC_EN
  logic [31:0] period_q, period_d;
`endif

  // Address decode, compare and next-state for every register.
  always_comb begin
    hit_cycle = (address == CYCLE_ADDR);
    hit_ack   = (address == ACK_ADDR);
`ifdef TIMER_PERIODIC_EN
    hit_period = (address == PERIOD_ADDR);
`else
    hit_period = 1'b0;
`endif
    // Compare uses pre-edge values, so a store in the match cycle cannot hide it.
    match = (cycle_count_q == interrupt_cycle_q);

    cycle_count_d = cycle_count_q + 32'd1;

    interrupt_cycle_d = interrupt_cycle_q;
`ifdef TIMER_PERIODIC_EN
    period_d = period_q;
    if (MemWrite && hit_period)
      period_d = data;
    if (match && (period_q != 32'd0))
      interrupt_cycle_d = interrupt_cycle_q + period_q;
`endif
    // A software store overrides any periodic reload in the same cycle.
    if (MemWrite && hit_cycle)
      interrupt_cycle_d = data;

    // Set wins over a simultaneous acknowledge so no interrupt is lost.
    irq_d = irq_q;
    if (MemWrite && hit_ack)
      irq_d = 1'b0;
    if (match)
      irq_d = 1'b1;
  end

  // State registers with synchronous reset that dominates every update.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count_q     <= 32'd0;
      interrupt_cycle_q <= 32'hffff_ffff;
      irq_q             <= 1'b0;
`ifdef TIMER_PERIODIC_EN
      period_q          <= 32'd0;
`endif
    end else begin
      cycle_count_q     <= cycle_count_d;
      interrupt_cycle_q <= interrupt_cycle_d;
      irq_q             <= irq_d;
`ifdef TIMER_PERIODIC_EN
      period_q          <= period_d;
`endif
    end
  end

  // Zero-latency load data and address-hit flag for the datapath.
  always_comb begin
    TimerAddress = (MemRead | MemWrite) & (hit_cycle | hit_ack | hit_period);
    cycle = 32'd0;
    if (MemRead && hit_cycle)
      cycle = cycle_count_q;
`ifdef TIMER_PERIODIC_EN
    else if (MemRead && hit_period)
      cycle = period_q;
`endif
  end

  assign TimerInterrupt = irq_q;

endmodule
